bidir_tx_ctrl: RTL
==================

BIDIR_TX_CTRL -- requirements
Module: bidir_tx_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 2, bus-turnaround idle cycles, legal range 0..15.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, level on OQI whenever not shifting a data bit.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as the following two ports.
REQ-004 IQC  input  1  clock; all state on rising edge.
REQ-005 IQR  input  1  asynchronous, active-high reset.
REQ-006 TX_VALID  input  1  fabric offers a transmit bit.
REQ-007 TX_DATA  input  1  transmit bit.
REQ-008 TX_LAST  input  1  marks final bit of a burst.
REQ-009 TX_READY  output  1  bit accepted when TX_VALID && TX_READY.
REQ-010 OQI  output  1  registered pad output data, to BIDIR OQI.
REQ-011 IE  output  1  registered pad output enable, to BIDIR IE.
REQ-012 INEN  output  1  registered pad input enable, to BIDIR INEN.
REQ-013 IZ  input  1  pad input data, from BIDIR IZ.
REQ-014 RX_DATA  output  1  registered sample of IZ.
REQ-015 RX_VALID  output  1  RX_DATA is a valid pad sample.
REQ-016 BUSY  output  1  high in any state except RX.

Function
REQ-017 SHALL implement four states: RX, TURN_TX, TX, TURN_RX.
REQ-018 RX: IE=0, INEN=1, TX_READY=0; TX_VALID=1 -> TURN_TX (or directly TX if TURN_CYCLES=0).
REQ-019 TURN_TX: IE=0, INEN=0; stay exactly TURN_CYCLES cycles, then TX.
REQ-020 TX: IE=1, INEN=0, TX_READY=1 combinationally.
REQ-021 An accepted bit SHALL appear on OQI on the cycle after acceptance; latency 1.
REQ-022 TX with TX_VALID=0 (bubble): stay in TX, IE stays 1, OQI=IDLE_LEVEL.
REQ-023 Acceptance with TX_LAST=1 -> TURN_RX; the last bit still drives OQI for one cycle with IE=1.
REQ-024 TURN_RX: IE=0, INEN=0, TX_READY=0, OQI=IDLE_LEVEL; stay TURN_CYCLES cycles, then RX (immediately if 0).
REQ-025 IE and INEN SHALL never both be 1 in the same cycle.
REQ-026 Turnaround counter SHALL be 4 bits; it loads TURN_CYCLES-1 on entry and counts down to 0.
REQ-027 TX_VALID arriving during TURN_RX SHALL be ignored until RX is re-entered; no bit lost (TX_READY=0).
REQ-028 RX_DATA SHALL register IZ every cycle; RX_VALID=1 only on cycles where INEN was 1 the previous cycle.

Reset
REQ-029 IQR=1 SHALL immediately force state RX, counter 0, IE=0, INEN=1, OQI=IDLE_LEVEL, RX_DATA=0, RX_VALID=0, TX_READY=0.
REQ-030 Reset mid-burst SHALL drop the burst without drive glitch: IE falls asynchronously.
REQ-031 After IQR deasserts, the first state change SHALL occur no earlier than the next rising IQC.

Structure
REQ-032 State enum (RX, TURN_TX, TX, TURN_RX) and TURN_CNT_W=4 SHALL live in the shared pp3 io package.
REQ-033 Turnaround counter SHALL be a sub-module bidir_turn_cnt (load, tick, done).
REQ-034 Block SHALL be a drop-in driver for the BIDIR INOUT mode; no pad primitives inside.

Verification
REQ-035 Reset: hold IQR 3 cycles with TX_VALID=1 -> IE=0, INEN=1, OQI=1, TX_READY=0 throughout.
REQ-036 Burst, TURN_CYCLES=2: 4 bits 1,0,1,1 with TX_LAST on bit 4 -> 2 cycles IE=0/INEN=0, then OQI=1,0,1,1 with IE=1, then 2 turnaround cycles, then INEN=1.
REQ-037 Bubble: TX_VALID low 2 cycles mid-burst -> IE stays 1, OQI=1 (IDLE_LEVEL), no bit dropped or duplicated.
REQ-038 TURN_CYCLES=0: single-bit burst 0 with TX_LAST -> IE=1 one cycle after TX_VALID, OQI=0 that cycle, INEN=1 next.
REQ-039 Reset mid-burst after bit 2 of 4 -> IE=0 same cycle, state RX, later burst restarts with full turnaround.
REQ-040 Assertion over all tests: never IE=1 && INEN=1; RX_VALID only when INEN was 1 the previous cycle.

Source files
------------

// File: rtl/bidir_tx_ctrl_pkg.sv
// Shared types and constants for the bidirectional pad transmit controller.
package bidir_tx_ctrl_pkg;

    // Width of the bus-turnaround down-counter
    localparam int TURN_CNT_W = 4;

    typedef logic [TURN_CNT_W-1:0] turn_cnt_t;

    // Controller states: receive, turn towards transmit, transmit, turn back
    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } bidir_state_e;

    // Counter preload for a turnaround of 'cycles' idle cycles (0 means none)
    function automatic turn_cnt_t turn_load_val(input int unsigned cycles);
        turn_cnt_t v;
        v = '0;
        if (cycles != 0) begin
            v = turn_cnt_t'(cycles - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/bidir_turn_cnt.sv
// Bus-turnaround down-counter: preloaded on turnaround entry, ticks to zero.
module bidir_turn_cnt
    import bidir_tx_ctrl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [TURN_CNT_W-1:0] i_load_val,
    input  logic                  i_tick,
    output logic                  o_done
);

    logic [TURN_CNT_W-1:0] r_cnt;

    // Load on entry, then decrement once per tick and hold at zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - turn_cnt_t'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/bidir_tx_ctrl.sv
// Bidirectional pad controller: drives OQI/IE/INEN of a BIDIR cell in
// INOUT mode, serialising fabric bits out and sampling the pad when idle.
// Pad-facing outputs are registered, so the pad view of every state lags
// the internal state by one clock; this keeps IE and INEN glitch-free and
// makes the last accepted bit drive for one cycle after leaving TX.
module bidir_tx_ctrl
    import bidir_tx_ctrl_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter logic        IDLE_LEVEL  = 1'b1
)
(
    input  logic IQC,
    input  logic IQR,
    input  logic TX_VALID,
    input  logic TX_DATA,
    input  logic TX_LAST,
    output logic TX_READY,
    output logic OQI,
    output logic IE,
    output logic INEN,
    input  logic IZ,
    output logic RX_DATA,
    output logic RX_VALID,
    output logic BUSY
);

    localparam turn_cnt_t LP_TURN_LOAD = turn_load_val(TURN_CYCLES);
    localparam bit        LP_ZERO_TURN = (TURN_CYCLES == 0);

    bidir_state_e r_state;
    logic         r_oqi;
    logic         r_ie;
    logic         r_inen;
    logic         r_rx_data;
    logic         r_rx_valid;

    logic w_accept;
    logic w_accept_last;
    logic w_cnt_load;
    logic w_cnt_tick;
    logic w_turn_done;

    assign w_accept      = (r_state == ST_TX) && TX_VALID;
    assign w_accept_last = w_accept && TX_LAST;

    // Preload whenever a turnaround is about to start; tick only inside one
    assign w_cnt_load = ((r_state == ST_RX) && TX_VALID) || w_accept_last;
    assign w_cnt_tick = (r_state == ST_TURN_TX) || (r_state == ST_TURN_RX);

    bidir_turn_cnt u_turn_cnt (
        .i_clk      (IQC),
        .i_rst      (IQR),
        .i_load     (w_cnt_load),
        .i_load_val (LP_TURN_LOAD),
        .i_tick     (w_cnt_tick),
        .o_done     (w_turn_done)
    );

    // State machine with registered pad controls; IE and INEN decode
    // disjoint states so they can never be high together
    always_ff @(posedge IQC or posedge IQR) begin
        if (IQR) begin
            r_state <= ST_RX;
            r_oqi   <= IDLE_LEVEL;
            r_ie    <= 1'b0;
            r_inen  <= 1'b1;
        end else begin
            r_ie   <= (r_state == ST_TX);
            r_inen <= (r_state == ST_RX);
            r_oqi  <= w_accept ? TX_DATA : IDLE_LEVEL;
            case (r_state)
                ST_RX: begin
                    if (TX_VALID) begin
                        r_state <= LP_ZERO_TURN ? ST_TX : ST_TURN_TX;
                    end
                end
                ST_TURN_TX: begin
                    if (w_turn_done) begin
                        r_state <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (w_accept_last) begin
                        r_state <= LP_ZERO_TURN ? ST_RX : ST_TURN_RX;
                    end
                end
                ST_TURN_RX: begin
                    if (w_turn_done) begin
                        r_state <= ST_RX;
                    end
                end
                default: begin
                    r_state <= ST_RX;
                end
            endcase
        end
    end

    // Pad sample path: data every cycle, valid only if the input buffer was enabled
    always_ff @(posedge IQC or posedge IQR) begin
        if (IQR) begin
            r_rx_data  <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_data  <= IZ;
            r_rx_valid <= r_inen;
        end
    end

    assign TX_READY = (r_state == ST_TX);
    assign BUSY     = (r_state != ST_RX);
    assign OQI      = r_oqi;
    assign IE       = r_ie;
    assign INEN     = r_inen;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;

endmodule
